// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM32 multi-cycle controller.
// Holds the sequencer state type, the opcode and condition encodings
// produced by the instruction decoder, the PC-source select encodings
// and small opcode-classification helpers used by the controller.
package cpu_pkg;

    // Register index written by the BL/BLX link write (w_lr selects it).
    localparam logic [3:0] LR_ADDR = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    // Full opcodes
    localparam logic [6:0] OP_MOV_I   = 7'b0000000;
    localparam logic [6:0] OP_HALT    = 7'b0000001;
    localparam logic [6:0] OP_ALU_R0  = 7'b0010000;
    localparam logic [6:0] OP_ALU_R1  = 7'b0110000;
    localparam logic [6:0] OP_B       = 7'b1000000;
    localparam logic [6:0] OP_BL      = 7'b1000100;
    localparam logic [6:0] OP_BX      = 7'b1000001;
    localparam logic [6:0] OP_BLX     = 7'b1000101;

    // Data-processing class prefixes (opcode[6:3]) and the CMP function code
    localparam logic [3:0] CLS_IMM    = 4'b0001;
    localparam logic [3:0] CLS_REG    = 4'b0011;
    localparam logic [3:0] CLS_RSR    = 4'b0111;
    localparam logic [2:0] FN_CMP     = 3'b010;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // PC source select
    localparam logic [1:0] SEL_PC_SEQ = 2'd0;  // PC+4
    localparam logic [1:0] SEL_PC_IMM = 2'd1;  // PC+8+(imm24<<2)
    localparam logic [1:0] SEL_PC_RM  = 2'd2;  // Rm

    function automatic logic is_alu_class(input logic [6:0] op);
        return (op[6:3] == CLS_IMM) || (op[6:3] == CLS_REG) || (op[6:3] == CLS_RSR);
    endfunction

    function automatic logic is_cmp(input logic [6:0] op);
        return is_alu_class(op) && (op[2:0] == FN_CMP);
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_MOV_I) || (op[6:3] == CLS_IMM);
    endfunction

    function automatic logic is_defined(input logic [6:0] op);
        return is_alu_class(op) || (op == OP_MOV_I) || (op == OP_ALU_R0) ||
               (op == OP_ALU_R1) || (op == OP_B) || (op == OP_BL) ||
               (op == OP_BX) || (op == OP_BLX);
    endfunction

endpackage

// File: rtl/cpu_controller_cond_check.sv
// Condition-code evaluator.
// Ports:
//   cond_i  [3:0]  instruction condition field
//   nzcv_i  [3:0]  status flags {N,Z,C,V}
//   pass_o         1 when the instruction should execute
module cpu_controller_cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;  // NV: never
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle FETCH -> DECODE -> EXECUTE -> WRITEBACK sequencer for the
// ARM32 core. Sole source of the state-changing strobes of the datapath.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                leaves IDLE (ignored elsewhere)
//   opcode, cond,        decoded instruction fields, held stable by IR
//   en_status            from DECODE onwards
//   nzcv                 status flags {N,Z,C,V}
//   imem_valid           instruction word valid (only looked at in FETCH)
//   imem_req, load_ir    instruction fetch request / IR capture
//   load_pc, sel_pc      PC update and its source
//   en_A, en_B, en_S     operand latches (Rn, Rm, Rs)
//   sel_B_imm, en_C      ALU B from imm12, ALU result latch
//   load_status          NZCV update
//   w_en, sel_w, w_lr    register write, link-data select, LR address select
//   waiting, halted      controller in IDLE / HALTED
// Handshake: in FETCH imem_req is held high; the cycle imem_valid is seen
// high is the transfer cycle (load_ir pulses in that same cycle, the only
// Mealy output). There is no timeout.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] opcode,
    input  logic [3:0] cond,
    input  logic       en_status,
    input  logic [3:0] nzcv,
    input  logic       imem_valid,
    output logic       imem_req,
    output logic       load_ir,
    output logic       load_pc,
    output logic [1:0] sel_pc,
    output logic       en_A,
    output logic       en_B,
    output logic       en_S,
    output logic       sel_B_imm,
    output logic       en_C,
    output logic       load_status,
    output logic       w_en,
    output logic       sel_w,
    output logic       w_lr,
    output logic       waiting,
    output logic       halted
);

    state_t state_q, state_d;
    logic   exec_ok_q, exec_ok_d;
    logic   cond_pass;

    cpu_controller_cond_check u_cond_check (
        .cond_i (cond),
        .nzcv_i (nzcv),
        .pass_o (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            exec_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exec_ok_q <= exec_ok_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exec_ok_d   = exec_ok_q;
        imem_req    = 1'b0;
        load_ir     = 1'b0;
        load_pc     = 1'b0;
        sel_pc      = SEL_PC_SEQ;
        en_A        = 1'b0;
        en_B        = 1'b0;
        en_S        = 1'b0;
        sel_B_imm   = 1'b0;
        en_C        = 1'b0;
        load_status = 1'b0;
        w_en        = 1'b0;
        sel_w       = 1'b0;
        w_lr        = 1'b0;
        waiting     = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                waiting = 1'b1;
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    load_ir = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                en_A = 1'b1;
                en_B = 1'b1;
                en_S = 1'b1;
                // Flags are frozen here so a status update during EXECUTE
                // cannot flip the writeback decision.
                exec_ok_d = cond_pass;
                if (opcode == OP_HALT || !is_defined(opcode)) state_d = ST_HALTED;
                else if (!cond_pass)                          state_d = ST_WRITEBACK;
                else                                          state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                en_C        = 1'b1;
                sel_B_imm   = uses_imm(opcode);
                load_status = en_status || is_cmp(opcode);
                state_d     = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                load_pc = 1'b1;
                state_d = ST_FETCH;
                if (exec_ok_q) begin
                    case (opcode)
                        OP_B:   sel_pc = SEL_PC_IMM;
                        OP_BL: begin
                            sel_pc = SEL_PC_IMM;
                            w_en   = 1'b1;
                            sel_w  = 1'b1;
                            w_lr   = 1'b1;
                        end
                        OP_BX:  sel_pc = SEL_PC_RM;
                        OP_BLX: begin
                            sel_pc = SEL_PC_RM;
                            w_en   = 1'b1;
                            sel_w  = 1'b1;
                            w_lr   = 1'b1;
                        end
                        // Only defined data ops reach here; CMP has no result write.
                        default: w_en = !is_cmp(opcode);
                    endcase
                end
            end
            ST_HALTED: halted = 1'b1;
            default:   state_d = ST_IDLE;
        endcase

        // Reset forces quiet outputs immediately, even mid-instruction.
        if (!rst_n) begin
            imem_req    = 1'b0;
            load_ir     = 1'b0;
            load_pc     = 1'b0;
            sel_pc      = SEL_PC_SEQ;
            en_A        = 1'b0;
            en_B        = 1'b0;
            en_S        = 1'b0;
            sel_B_imm   = 1'b0;
            en_C        = 1'b0;
            load_status = 1'b0;
            w_en        = 1'b0;
            sel_w       = 1'b0;
            w_lr        = 1'b0;
            waiting     = 1'b1;
            halted      = 1'b0;
        end
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multi-cycle sequencer for the ARM32 core: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
- Consumes the instruction decoder's opcode/cond/en_status plus the NZCV flags.
- Drives the instruction-memory handshake, IR/PC loads, register-file operand/write enables, ALU result latch and status-register update.
- Sits between instruction memory, the decoder and the datapath; it is the only source of state-changing strobes.

Parameters:
- LR_ADDR, 4'd14, register index written by BL/BLX link.

Ports:
- clk  input  1  system clock (all logic on rising edge)
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; leaves IDLE
- opcode  input  7  decoded opcode
- cond  input  4  condition field
- en_status  input  1  S bit
- nzcv  input  4  status flags {N,Z,C,V}
- imem_valid  input  1  instruction word valid this cycle
- imem_req  output  1  instruction fetch request
- load_ir  output  1  capture instruction word into IR
- load_pc  output  1  update PC
- sel_pc  output  2  0 = PC+4, 1 = PC+8+(imm24<<2), 2 = Rm
- en_A, en_B, en_S  output  1 each  latch Rn, Rm, Rs operands
- sel_B_imm  output  1  ALU B from imm12
- en_C  output  1  latch ALU result
- load_status  output  1  update NZCV
- w_en  output  1  register-file write
- sel_w  output  1  0 = ALU result, 1 = PC+4 link
- w_lr  output  1  write address = LR_ADDR instead of rd
- waiting, halted  output  1 each  controller in IDLE / HALTED

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- Reset:
  - Applies on any clk edge with rst_n=0, including mid-instruction.
  - Next state IDLE; exec_ok=0; imem_req dropped.
  - All strobes 0; waiting=1, halted=0.
- IDLE: waiting=1. start=1 -> FETCH. Otherwise stay.
- FETCH:
  - imem_req=1.
  - imem_valid=1 -> load_ir=1 in the same cycle (only Mealy output), next DECODE.
  - Otherwise stay; no timeout.
  - imem_valid is ignored in every other state.
- DECODE:
  - en_A=en_B=en_S=1.
  - Register exec_ok <= cond_pass(cond, nzcv). Flags are sampled here so an EXECUTE-cycle status update cannot change the decision.
  - opcode HALT (0000001) or an undefined opcode -> HALTED, regardless of cond.
  - exec_ok false -> WRITEBACK; otherwise -> EXECUTE.
- EXECUTE:
  - en_C=1.
  - sel_B_imm=1 for the immediate class (0001xxx) and for MOV imm (0000000).
  - load_status=1 if en_status=1, or the opcode is CMP (xxxx010 in classes 0001/0011/0111).
  - Next WRITEBACK.
- WRITEBACK:
  - exec_ok=0: load_pc=1, sel_pc=0, nothing else.
  - ALU/MOV (0000000, 0001xxx, 0011xxx, 0111xxx, 0010000, 0110000), excluding CMP: w_en=1, sel_w=0, w_lr=0; load_pc=1, sel_pc=0.
  - CMP: load_pc=1, sel_pc=0 only.
  - B (1000000): load_pc=1, sel_pc=1.
  - BL (1000100): load_pc=1, sel_pc=1, plus w_en=1, sel_w=1, w_lr=1.
  - BX (1000001): load_pc=1, sel_pc=2.
  - BLX (1000101): load_pc=1, sel_pc=2, plus the link write.
  - Next FETCH.
- HALTED: halted=1. Sticky until reset; start ignored.
- start is ignored outside IDLE.
- cond_pass:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 -> 0 (never).
- Latency: with imem_valid in the first FETCH cycle, an executed instruction takes 4 cycles and a condition-failed one takes 3. Each imem wait cycle adds 1.
- Strobe outputs are Moore (state plus latched exec_ok plus opcode held stable by IR), except load_ir.

Decomposition:
- Shared package cpu_pkg holds:
  - state_t enum;
  - opcode localparams (OP_HALT, OP_MOV_I, class prefixes, OP_B, OP_BL, OP_BX, OP_BLX);
  - condition-code localparams;
  - sel_pc encodings.
- One combinational sub-module cond_check (cond, nzcv -> pass).

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, then start=1 -> waiting=1 and all strobes 0 during reset; imem_req=1 exactly one cycle after start.
- ADD imm, cond=1110, imem_valid delayed 2 cycles:
  - imem_req held 3 cycles; load_ir on the valid cycle;
  - then en_A/B/S, then en_C with sel_B_imm=1, then w_en=1 with load_pc/sel_pc=0.
- CMP reg, en_status=0: load_status=1 in EXECUTE; w_en never asserted in WRITEBACK.
- BEQ, nzcv=0000: DECODE goes straight to WRITEBACK; load_pc=1, sel_pc=0; no en_C; 3 cycles.
- BL with exec_ok latched while a prior flag update is in flight: WRITEBACK asserts w_en=1, sel_w=1, w_lr=1, load_pc=1, sel_pc=1.
- HALT, then start pulses: halted=1 and stays; rst_n=0 in EXECUTE of a later run returns to IDLE with no w_en.
